pipelined_mem_interface: RTL and testbench

Parametrised successor to the team's single-port synchronous RAM. It adds byte-strobed writes, a configurable read latency with a valid flag, selectable read-during-write behaviour, out-of-range error reporting and a hardware zero-fill (init) sequencer. It sits behind the APB slave (or any simple bus bridge) as its memory target.

---
 rtl/pipelined_mem_interface_pkg.sv | 35 +++
 rtl/pipelined_mem_interface_rd_pipe.sv | 42 ++++
 rtl/pipelined_mem_interface.sv | 128 ++++++++++++
 tb/tb_pipelined_mem_interface.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_mem_interface_pkg.sv
// Shared types, constants and helpers for pipelined_mem_interface.
// The strobe-merge helper works on the widest supported word; callers cast in and out.
package mem_if_pkg;

  typedef enum logic {IDLE = 1'b0, INIT = 1'b1} state_e;

  localparam int RDW_READ_OLD    = 0;
  localparam int RDW_WRITE_FIRST = 1;

  localparam int MAX_DW = 512;
  localparam int MAX_NB = MAX_DW / 8;

  function automatic logic [MAX_DW-1:0] strb_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_NB-1:0] strb);
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int b = 0; b < MAX_NB; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  function automatic bit cfg_ok(input int aw, input int dw, input int depth,
                                input int lat, input int rdw);
    bit ok;
    ok = (aw >= 1) && (aw <= 30);
    ok = ok && (dw >= 8) && (dw % 8 == 0) && (dw <= MAX_DW);
    ok = ok && (lat >= 1) && (lat <= 4);
    ok = ok && (rdw == RDW_READ_OLD || rdw == RDW_WRITE_FIRST);
    if (ok) ok = (depth >= 1) && (depth <= (1 << aw));
    return ok;
  endfunction

endpackage

// File: rtl/pipelined_mem_interface_rd_pipe.sv
// Read-return shift register: RD_LATENCY stages of data+valid. Data stages only
// advance behind a valid, so the output word holds between pulses.
module mem_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o
);

  logic [RD_LATENCY-1:0]                 vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] dat_pipe_q, dat_pipe_d;

  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    dat_pipe_d    = dat_pipe_q;
    vld_pipe_d[0] = vld_i;
    if (vld_i) dat_pipe_d[0] = data_i;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      if (vld_pipe_q[i-1]) dat_pipe_d[i] = dat_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_pipe_q <= dat_pipe_d;
    end
  end

  assign rdata_o  = dat_pipe_q[RD_LATENCY-1];
  assign rvalid_o = vld_pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/pipelined_mem_interface.sv
// Single-port-style RAM target: byte-strobed writes, pipelined reads with valid,
// selectable read-during-write, range errors and a zero-fill sequencer.
module pipelined_mem_interface
  import mem_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = RDW_READ_OLD
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic [ADDR_WIDTH-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    rd_en_i,
  input  logic [ADDR_WIDTH-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rvalid_o,
  input  logic                    init_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int                    NB       = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEM_DEPTH - 1);

  if (!cfg_ok(ADDR_WIDTH, DATA_WIDTH, MEM_DEPTH, RD_LATENCY, RDW_MODE)) begin : g_bad_cfg
    $error("pipelined_mem_interface: illegal parameter combination");
  end

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  busy, wr_inr, rd_inr, wr_ok, rd_ok;
  logic                  we;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd, rd_old, rd_word;
  logic [NB-1:0]         ws;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  assign busy   = (state_q == INIT);
  assign wr_inr = ({1'b0, waddr_i} < DEPTH_L);
  assign rd_inr = ({1'b0, raddr_i} < DEPTH_L);
  assign wr_ok  = wr_en_i && !busy && wr_inr;
  assign rd_ok  = rd_en_i && !busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (init_i) begin
        state_d = INIT;
        cnt_d   = '0;
      end
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Rejected-while-busy and out-of-range requests share one pulse.
  always_comb begin
    err_d = (wr_en_i && (busy || !wr_inr)) || (rd_en_i && (busy || !rd_inr));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // One write port shared by the zero-fill sequencer and the bus.
  always_comb begin
    we = wr_ok;
    wa = waddr_i;
    wd = wdata_i;
    ws = wstrb_i;
    if (busy) begin
      we = 1'b1;
      wa = cnt_q;
      wd = '0;
      ws = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (ws[b]) mem_q[wa][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_old  = rd_inr ? mem_q[raddr_i] : '0;
    rd_word = rd_old;
    if (RDW_MODE == RDW_WRITE_FIRST && wr_ok && rd_inr && waddr_i == raddr_i)
      rd_word = DATA_WIDTH'(strb_merge(MAX_DW'(rd_old), MAX_DW'(wdata_i), MAX_NB'(wstrb_i)));
  end

  mem_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .vld_i    (rd_ok),
    .data_i   (rd_word),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o)
  );

  assign busy_o = busy;
  assign err_o  = err_q;

endmodule

// File: tb/tb_pipelined_mem_interface.sv
// Directed bench: instance A (depth 1000, latency 2, read-old) and
// instance B (depth 16, latency 4, write-first).
module tb_pipelined_mem_interface;

  typedef struct packed {
    logic        wr_en;
    logic [3:0]  wstrb;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic        rd_en;
    logic [9:0]  raddr;
    logic        init;
  } req_t;

  typedef struct {
    bit          sel;
    bit          wr;
    logic [3:0]  strb;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    bit          rd;
    logic [9:0]  raddr;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  req_t             ra, rb;
  logic [1:0][31:0] rdata;
  logic [1:0]       rvalid, busy, err;
  int               n_tests = 0;
  int               n_fail  = 0;
  vec_t             tbl[22];
  logic [31:0]      exp_b[16];

  always #5 clk = ~clk;

  pipelined_mem_interface #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(1000), .RD_LATENCY(2), .RDW_MODE(0)
  ) u_a (
    .clk(clk), .reset_n(rst_n), .wr_en_i(ra.wr_en), .wstrb_i(ra.wstrb), .waddr_i(ra.waddr),
    .wdata_i(ra.wdata), .rd_en_i(ra.rd_en), .raddr_i(ra.raddr), .rdata_o(rdata[0]),
    .rvalid_o(rvalid[0]), .init_i(ra.init), .busy_o(busy[0]), .err_o(err[0])
  );

  pipelined_mem_interface #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_DEPTH(16), .RD_LATENCY(4), .RDW_MODE(1)
  ) u_b (
    .clk(clk), .reset_n(rst_n), .wr_en_i(rb.wr_en), .wstrb_i(rb.wstrb), .waddr_i(rb.waddr[3:0]),
    .wdata_i(rb.wdata), .rd_en_i(rb.rd_en), .raddr_i(rb.raddr[3:0]), .rdata_o(rdata[1]),
    .rvalid_o(rvalid[1]), .init_i(rb.init), .busy_o(busy[1]), .err_o(err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply one transaction for a cycle, then watch err/rvalid/rdata for L+1 cycles.
  task automatic run_vec(input vec_t v);
    int          lat;
    req_t        r;
    logic [7:0]  vmask, emask;
    logic [31:0] d_at, d_hold;
    lat   = v.sel ? 4 : 2;
    vmask = '0;
    emask = '0;
    d_at  = '0;
    d_hold = '0;
    r = '0;
    r.wr_en = v.wr; r.wstrb = v.strb; r.waddr = v.waddr; r.wdata = v.wdata;
    r.rd_en = v.rd; r.raddr = v.raddr;
    if (v.sel) rb = r; else ra = r;
    @(negedge clk);
    if (v.sel) rb = '0; else ra = '0;
    for (int k = 0; k <= lat; k++) begin
      if (rvalid[v.sel]) vmask[k] = 1'b1;
      if (err[v.sel])    emask[k] = 1'b1;
      if (k == lat-1) d_at   = rdata[v.sel];
      if (k == lat)   d_hold = rdata[v.sel];
      if (k < lat) @(negedge clk);
    end
    chk("err pulse", 32'(emask), v.exp_err ? 32'd1 : 32'd0);
    chk("rvalid timing", 32'(vmask), v.rd ? (32'd1 << (lat-1)) : 32'd0);
    if (v.rd) begin
      chk("rdata", d_at, v.exp_rdata);
      chk("rdata hold", d_hold, v.exp_rdata);
    end
  endtask

  // Back-to-back reads 0..n-1 on B; pulse i must land at negedge L+i with exp_b[i].
  task automatic b_burst(input int n);
    int got;
    got = 0;
    for (int j = 0; j < n + 7; j++) begin
      if (j > 0 && rvalid[1]) begin
        chk("burst slot", 32'(j), 32'(4 + got));
        if (got < 16) chk("burst data", rdata[1], exp_b[got]);
        got++;
      end
      rb.rd_en = (j < n);
      rb.raddr = 10'(j);
      @(negedge clk);
    end
    rb = '0;
    chk("burst count", 32'(got), 32'(n));
  endtask

  task automatic b_write(input int a, input logic [31:0] d);
    rb = '0;
    rb.wr_en = 1'b1; rb.wstrb = 4'hF; rb.waddr = 10'(a); rb.wdata = d;
    @(negedge clk);
    rb = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   busy_cnt, err_cnt, rv_cnt;
    vec_t v;

    //        sel wr strb   waddr    wdata         rd raddr    err rdata
    tbl[0]  = '{0, 1, 4'hF, 10'h010, 32'hDEADBEEF, 0, 10'h000, 0, 32'h0};
    tbl[1]  = '{0, 0, 4'h0, 10'h000, 32'h0,        1, 10'h010, 0, 32'hDEADBEEF};
    tbl[2]  = '{0, 1, 4'h5, 10'h010, 32'h11223344, 0, 10'h000, 0, 32'h0};
    tbl[3]  = '{0, 0, 4'h0, 10'h000, 32'h0,        1, 10'h010, 0, 32'hDE22BE44};
    tbl[4]  = '{0, 1, 4'h0, 10'h010, 32'hFFFFFFFF, 0, 10'h000, 0, 32'h0};
    tbl[5]  = '{0, 0, 4'h0, 10'h000, 32'h0,        1, 10'h010, 0, 32'hDE22BE44};
    tbl[6]  = '{0, 1, 4'hF, 10'd999, 32'hCAFEF00D, 0, 10'h000, 0, 32'h0};
    tbl[7]  = '{0, 1, 4'hF, 10'd1000, 32'h55555555, 1, 10'd1001, 1, 32'h0};
    tbl[8]  = '{0, 0, 4'h0, 10'h000, 32'h0,        1, 10'd999,  0, 32'hCAFEF00D};
    tbl[9]  = '{0, 0, 4'h0, 10'h000, 32'h0,        1, 10'd1023, 1, 32'h0};
    tbl[10] = '{0, 1, 4'hF, 10'd1020, 32'h12345678, 0, 10'h000, 1, 32'h0};
    tbl[11] = '{0, 1, 4'hF, 10'h020, 32'h0,        0, 10'h000, 0, 32'h0};
    tbl[12] = '{0, 1, 4'hF, 10'h020, 32'hA5A5A5A5, 1, 10'h020, 0, 32'h0};
    tbl[13] = '{0, 0, 4'h0, 10'h000, 32'h0,        1, 10'h020, 0, 32'hA5A5A5A5};
    tbl[14] = '{0, 1, 4'hF, 10'h031, 32'h12345678, 0, 10'h000, 0, 32'h0};
    tbl[15] = '{0, 1, 4'hF, 10'h030, 32'h00000009, 1, 10'h031, 0, 32'h12345678};
    tbl[16] = '{0, 0, 4'h0, 10'h000, 32'h0,        1, 10'h010, 0, 32'hDE22BE44};
    tbl[17] = '{1, 1, 4'hF, 10'h002, 32'h0,        0, 10'h000, 0, 32'h0};
    tbl[18] = '{1, 1, 4'hF, 10'h002, 32'hA5A5A5A5, 1, 10'h002, 0, 32'hA5A5A5A5};
    tbl[19] = '{1, 1, 4'hF, 10'h003, 32'h0,        0, 10'h000, 0, 32'h0};
    tbl[20] = '{1, 1, 4'h5, 10'h003, 32'h11223344, 1, 10'h003, 0, 32'h00220044};
    tbl[21] = '{1, 0, 4'h0, 10'h000, 32'h0,        1, 10'h003, 0, 32'h00220044};

    rst_n = 1'b0;
    ra = '0;
    rb = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset rdata", rdata[s], 32'h0);
      chk("reset rvalid", 32'(rvalid[s]), 32'h0);
      chk("reset busy", 32'(busy[s]), 32'h0);
      chk("reset err", 32'(err[s]), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Zero-fill on B: busy for 16 cycles, mid-init read errors, re-init ignored.
    rb.init = 1'b1;
    @(negedge clk);
    rb.init = 1'b0;
    busy_cnt = 0; err_cnt = 0; rv_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy[1])   busy_cnt++;
      if (err[1])    err_cnt++;
      if (rvalid[1]) rv_cnt++;
      rb.rd_en = (k == 4);
      rb.raddr = 10'd1;
      rb.init  = (k == 8);
      @(negedge clk);
    end
    rb = '0;
    chk("init busy cycles", 32'(busy_cnt), 32'd16);
    chk("busy-read err", 32'(err_cnt), 32'd1);
    chk("busy-read rvalid", 32'(rv_cnt), 32'd0);
    chk("idle after init", 32'(busy[1]), 32'd0);

    for (int i = 0; i < 16; i++) exp_b[i] = 32'h0;
    b_burst(16);

    for (int i = 0; i < 8; i++) begin
      exp_b[i] = 32'h100 + 32'(i);
      b_write(i, exp_b[i]);
    end
    b_burst(8);

    // init_i with a read in the same idle cycle: read served with pre-fill data.
    rb.init = 1'b1; rb.rd_en = 1'b1; rb.raddr = 10'd5;
    @(negedge clk);
    rb = '0;
    rv_cnt = 0;
    chk("init entry busy", 32'(busy[1]), 32'd1);
    for (int j = 1; j <= 6; j++) begin
      if (rvalid[1]) begin
        chk("init+read slot", 32'(j), 32'd4);
        chk("init+read data", rdata[1], 32'h105);
        rv_cnt++;
      end
      @(negedge clk);
    end
    chk("init+read count", 32'(rv_cnt), 32'd1);
    for (int k = 0; k < 40 && busy[1]; k++) @(negedge clk);
    chk("init done", 32'(busy[1]), 32'd0);

    // Reset mid-init with a read in flight: everything clears at once.
    b_write(15, 32'h00001234);
    rb.init = 1'b1; rb.rd_en = 1'b1; rb.raddr = 10'd6;
    @(negedge clk);
    rb = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", 32'(busy[1]), 32'd0);
    chk("async reset rvalid", 32'(rvalid[1]), 32'd0);
    chk("async reset rdata B", rdata[1], 32'h0);
    chk("async reset rdata A", rdata[0], 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    busy_cnt = 0; rv_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy[1])   busy_cnt++;
      if (rvalid[1]) rv_cnt++;
      @(negedge clk);
    end
    chk("post-reset busy", 32'(busy_cnt), 32'd0);
    chk("post-reset rvalid", 32'(rv_cnt), 32'd0);

    v = '{1, 0, 4'h0, 10'h000, 32'h0, 1, 10'd15, 0, 32'h00001234};
    run_vec(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
